instr_fetch_unit: RTL

Instruction fetch stage that supplies the control unit with its `OPCODE` and the datapath with decoded instruction fields. Holds the fetch PC, issues requests to a synchronous instruction memory with one-cycle read latency, and presents each instruction through a valid/ready handshake backed by a one-entry skid buffer. Accepts branch redirects from execute, flushing everything in flight.

---
 rtl/ifu_pkg.sv | 34 +++
 rtl/ifu_skid_buf.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit: opcode constants,
// instruction field bit positions, the fetch FSM state encoding and the
// default reset fetch address.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_WIDTH  = 32;

    localparam logic [5:0]  OP_RTYPE     = 6'b000000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_RUN      = 2'd1,
        S_REDIRECT = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_skid_buf.sv
// ---------------------------------------------------------------------------
// ifu_skid_buf
// One-entry holding buffer for an instruction word and its PC. Catches a
// memory response that arrives while the output register is stalled.
// Priority: flush > push > pop. A push in the same cycle as a pop replaces
// the entry (the old one moves to the output register elsewhere).
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   flush       drop the entry
//   push        load push_instr/push_pc, mark valid
//   pop         entry consumed, mark empty
//   push_instr  instruction word to store
//   push_pc     PC of that word
//   valid       entry present
//   instr, pc   stored entry
// ---------------------------------------------------------------------------
module ifu_skid_buf
    import ifu_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [INSTR_WIDTH-1:0] push_instr,
    input  logic [PC_WIDTH-1:0]    push_pc,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            instr <= push_instr;
            pc    <= push_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: holds the fetch PC, issues reads to a synchronous instruction
// memory (read data valid the cycle after the request), and presents each
// instruction with decoded fields through a valid/ready handshake backed by
// a one-entry skid buffer. Branch redirects flush everything in flight.
//
// Optional feature: define IFU_ALIGN_CHECK_EN to add the sticky misalign_err
// output, raised by a redirect whose target has nonzero low bits.
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   imem_req, imem_addr        read strobe and word-aligned byte address
//   imem_rdata                 read data, one cycle after imem_req
//   branch_taken/target        one-cycle redirect from execute
//   out_valid, out_ready       output handshake (fire = both high)
//   instr, pc_out              instruction word and its address
//   OPCODE, rs, rt, rd,
//   shamt, funct               slices of instr
//   misalign_err               sticky misaligned-target flag (optional)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_BOOT     | first cycle after reset, nothing issued, redirects ignored
// S_RUN      | normal fetching, one request per cycle when there is room
// S_REDIRECT | bubble after a redirect, fetch PC already at the target
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(IFU_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [5:0]             OPCODE,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [4:0]             shamt,
    output logic [5:0]             funct
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic                   misalign_err
`endif
);

    ifu_state_e             state;
    logic [PC_WIDTH-1:0]    fpc;
    logic [PC_WIDTH-1:0]    req_pc;
    logic                   pend;
    logic                   drop;

    logic                   skid_valid;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;
    logic                   skid_push;
    logic                   skid_pop;

    logic                   redirect;
    logic                   fire;
    logic                   resp;
    logic [1:0]             occ;
    logic [1:0]             occ_after;
    logic                   issue;
    logic                   out_load;
    logic                   out_from_skid;
    logic [INSTR_WIDTH-1:0] load_instr;
    logic [PC_WIDTH-1:0]    load_pc;

    // Nothing is in flight during BOOT, so a redirect there has no effect.
    assign redirect = branch_taken && (state != S_BOOT);
    assign fire     = out_valid && out_ready;
    assign resp     = pend && !drop;

    // occ never exceeds 2, and fire implies out_valid, so occ - fire cannot wrap.
    assign occ       = 2'(out_valid) + 2'(skid_valid) + 2'(pend);
    assign occ_after = occ - 2'(fire);
    assign issue     = (state == S_RUN) && !branch_taken && (occ_after < 2'd2);

    assign imem_req  = issue;
    assign imem_addr = fpc;

    // Routing of the skid entry and of this cycle's memory response.
    always_comb begin
        out_load      = 1'b0;
        out_from_skid = 1'b0;
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        if (!redirect) begin
            if (skid_valid) begin
                // Older entry goes out first; a response arriving now
                // takes its place in the skid.
                if (fire) begin
                    out_load      = 1'b1;
                    out_from_skid = 1'b1;
                    skid_pop      = 1'b1;
                    skid_push     = resp;
                end
            end else if (resp) begin
                if (!out_valid || fire) begin
                    out_load = 1'b1;
                end else begin
                    skid_push = 1'b1;
                end
            end
        end
    end

    assign load_instr = out_from_skid ? skid_instr : imem_rdata;
    assign load_pc    = out_from_skid ? skid_pc    : req_pc;

    ifu_skid_buf #(
        .PC_WIDTH (PC_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (skid_push),
        .pop        (skid_pop),
        .push_instr (imem_rdata),
        .push_pc    (req_pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_BOOT;
            fpc       <= RESET_PC;
            req_pc    <= RESET_PC;
            pend      <= 1'b0;
            drop      <= 1'b0;
            out_valid <= 1'b0;
            instr     <= '0;
            pc_out    <= '0;
        end else begin
            unique case (state)
                S_BOOT:     state <= S_RUN;
                S_RUN:      if (branch_taken) state <= S_REDIRECT;
                S_REDIRECT: state <= S_RUN;
                default:    state <= S_BOOT;
            endcase

            if (redirect) begin
                fpc       <= branch_target & ~PC_WIDTH'(3);
                out_valid <= 1'b0;
                pend      <= 1'b0;
                // With one-cycle read latency the outstanding response lands
                // in this very cycle and is discarded here by the redirect,
                // so nothing stale is left to drop afterwards.
                drop      <= 1'b0;
            end else begin
                pend <= issue;
                if (pend && drop) begin
                    drop <= 1'b0;
                end
                if (issue) begin
                    fpc    <= fpc + PC_WIDTH'(4);
                    req_pc <= fpc;
                end
                if (out_load) begin
                    out_valid <= 1'b1;
                    instr     <= load_instr;
                    pc_out    <= load_pc;
                end else if (fire) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect && (branch_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`endif

    assign OPCODE = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct  = instr[FUNCT_MSB:FUNCT_LSB];

endmodule
